// File: rtl/aha_tlx_fwd_dl_rx_if.sv
// TLX forward-channel receive bundle: payload in, credit return out,
// buffered AXI-Stream out plus status.
interface aha_tlx_fwd_dl_rx_if #(
  parameter int DATA_W = 40,
  parameter int LVL_W  = 4
);
  logic              TLX_FWD_PAYLOAD_TVALID;
  logic              TLX_FWD_PAYLOAD_TREADY;
  logic [DATA_W-1:0] TLX_FWD_PAYLOAD_TDATA;
  logic              TLX_FWD_FLOW_TVALID;
  logic              TLX_FWD_FLOW_TREADY;
  logic [1:0]        TLX_FWD_FLOW_TDATA;
  logic              M_TVALID;
  logic              M_TREADY;
  logic [DATA_W-1:0] M_TDATA;
  logic [LVL_W-1:0]  FIFO_LEVEL;
  logic              OVERFLOW_ERR;

  modport slave (
    input  TLX_FWD_PAYLOAD_TVALID,
    input  TLX_FWD_PAYLOAD_TDATA,
    input  TLX_FWD_FLOW_TREADY,
    input  M_TREADY,
    output TLX_FWD_PAYLOAD_TREADY,
    output TLX_FWD_FLOW_TVALID,
    output TLX_FWD_FLOW_TDATA,
    output M_TVALID,
    output M_TDATA,
    output FIFO_LEVEL,
    output OVERFLOW_ERR
  );

  modport master (
    output TLX_FWD_PAYLOAD_TVALID,
    output TLX_FWD_PAYLOAD_TDATA,
    output TLX_FWD_FLOW_TREADY,
    output M_TREADY,
    input  TLX_FWD_PAYLOAD_TREADY,
    input  TLX_FWD_FLOW_TVALID,
    input  TLX_FWD_FLOW_TDATA,
    input  M_TVALID,
    input  M_TDATA,
    input  FIFO_LEVEL,
    input  OVERFLOW_ERR
  );
endinterface

// File: rtl/aha_tlx_fwd_dl_rx.sv
// TLX forward receive data link: credit-gated payload FIFO with
// first-word-fall-through output and batched credit return.
module aha_tlx_fwd_dl_rx #(
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_W     = 40
) (
  input  logic               TLX_CLK,
  input  logic               TLX_RESET,
  aha_tlx_fwd_dl_rx_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {IDLE, SEND} flow_st_e;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     level;
  logic [LW-1:0]     pending;
  logic [LW-1:0]     pending_n;
  logic [1:0]        fdata;
  logic [1:0]        fdata_n;
  flow_st_e          st;
  flow_st_e          st_n;
  logic              ready_q;
  logic              ovf;
  logic              full;
  logic              push;
  logic              wr_en;
  logic              pop;
  logic              flow_hs;

  function automatic logic [1:0] cap3(
    input logic [LW-1:0] v
  );
    return (v >= LW'(3)) ? 2'd3 : v[1:0];
  endfunction

  assign full    = (level == LW'(FIFO_DEPTH));
  assign push    = bus.TLX_FWD_PAYLOAD_TVALID & ready_q;
  assign wr_en   = push & ~full;
  assign pop     = (level != '0) & bus.M_TREADY;
  assign flow_hs = (st == SEND) & bus.TLX_FWD_FLOW_TREADY;

  // Loaded credit value stays frozen while a beat waits for ready.
  always_comb begin
    st_n      = st;
    fdata_n   = fdata;
    pending_n = pending + LW'(pop);
    unique case (st)
      IDLE: begin
        if (pending != '0) begin
          st_n    = SEND;
          fdata_n = cap3(pending);
        end
      end
      SEND: begin
        if (flow_hs) begin
          pending_n = pending - LW'(fdata) + LW'(pop);
          if (pending_n != '0) fdata_n = cap3(pending_n);
          else                 st_n    = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge TLX_CLK or posedge TLX_RESET) begin
    if (TLX_RESET) begin
      ready_q <= 1'b0;
      st      <= IDLE;
      fdata   <= 2'd0;
      pending <= LW'(FIFO_DEPTH);
      level   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ovf     <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      st      <= st_n;
      fdata   <= fdata_n;
      pending <= pending_n;
      level   <= level + LW'(wr_en) - LW'(pop);
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (push & full) ovf <= 1'b1;
    end
  end

  always_ff @(posedge TLX_CLK) begin
    if (wr_en) mem[wr_ptr] <= bus.TLX_FWD_PAYLOAD_TDATA;
  end

  assign bus.TLX_FWD_PAYLOAD_TREADY = ready_q;
  assign bus.TLX_FWD_FLOW_TVALID    = (st == SEND);
  assign bus.TLX_FWD_FLOW_TDATA     = fdata;
  assign bus.M_TVALID               = (level != '0);
  assign bus.M_TDATA                = mem[rd_ptr];
  assign bus.FIFO_LEVEL             = level;
  assign bus.OVERFLOW_ERR           = ovf;
endmodule

// File: tb/tb_aha_tlx_fwd_dl_rx.sv
// Self-checking bench for aha_tlx_fwd_dl_rx: directed scenarios plus
// randomized traffic against a queue/credit-count reference model.
module tb_aha_tlx_fwd_dl_rx;
  localparam int DEPTH = 8;
  localparam int DW    = 40;
  localparam int LW    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aha_tlx_fwd_dl_rx_if #(.DATA_W(DW), .LVL_W(LW)) bus ();

  aha_tlx_fwd_dl_rx #(.FIFO_DEPTH(DEPTH), .DATA_W(DW)) dut (
    .TLX_CLK   (clk),
    .TLX_RESET (rst),
    .bus       (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] mq[$];
  bit m_rdy;
  bit m_fv;
  bit m_ovf;
  int m_pend;
  int m_fd;
  int m_tx;

  function automatic int min3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_rdy  = 0;
    m_fv   = 0;
    m_ovf  = 0;
    m_pend = DEPTH;
    m_fd   = 0;
    m_tx   = 0;
  endtask

  task automatic drive(input bit pv, input logic [DW-1:0] pd,
                       input bit mr, input bit fr);
    bus.TLX_FWD_PAYLOAD_TVALID = pv;
    bus.TLX_FWD_PAYLOAD_TDATA  = pd;
    bus.M_TREADY               = mr;
    bus.TLX_FWD_FLOW_TREADY    = fr;
  endtask

  // One clock: drive at negedge, reference model steps at posedge.
  task automatic cyc(input bit pv, input logic [DW-1:0] pd,
                     input bit mr, input bit fr);
    bit pop, push, full, hs;
    int np;
    drive(pv, pd, mr, fr);
    @(posedge clk);
    pop  = (mq.size() != 0) && mr;
    push = pv && m_rdy;
    full = (mq.size() == DEPTH);
    hs   = m_fv && fr;
    if (hs) m_tx += m_fd;
    if (push && !full) m_tx -= 1;
    if (!m_fv) begin
      if (m_pend != 0) begin
        m_fv = 1;
        m_fd = min3(m_pend);
      end
      m_pend += int'(pop);
    end else if (hs) begin
      np = m_pend - m_fd + int'(pop);
      m_pend = np;
      if (np != 0) m_fd = min3(np);
      else m_fv = 0;
    end else begin
      m_pend += int'(pop);
    end
    if (pop) void'(mq.pop_front());
    if (push) begin
      if (full) m_ovf = 1;
      else mq.push_back(pd);
    end
    m_rdy = 1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, '0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int exp_fd[3] = '{3, 3, 2};
    rst = 1'b1;
    drive(0, '0, 0, 0);
    model_reset();
    @(negedge clk);
    n_cmp++;
    if (bus.TLX_FWD_PAYLOAD_TREADY !== 1'b0) begin
      n_err++;
      $display("FAIL rst_ptready: got %b want 0", bus.TLX_FWD_PAYLOAD_TREADY);
    end
    n_cmp++;
    if (bus.TLX_FWD_FLOW_TVALID !== 1'b0) begin
      n_err++;
      $display("FAIL rst_ftvalid: got %b want 0", bus.TLX_FWD_FLOW_TVALID);
    end
    n_cmp++;
    if (bus.TLX_FWD_FLOW_TDATA !== 2'd0) begin
      n_err++;
      $display("FAIL rst_ftdata: got %0d want 0", bus.TLX_FWD_FLOW_TDATA);
    end
    n_cmp++;
    if (bus.M_TVALID !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mtvalid: got %b want 0", bus.M_TVALID);
    end
    n_cmp++;
    if (bus.FIFO_LEVEL !== 4'd0) begin
      n_err++;
      $display("FAIL rst_level: got %0d want 0", bus.FIFO_LEVEL);
    end
    n_cmp++;
    if (bus.OVERFLOW_ERR !== 1'b0) begin
      n_err++;
      $display("FAIL rst_ovf: got %b want 0", bus.OVERFLOW_ERR);
    end
    rst = 1'b0;
    n_cmp++;
    if (bus.TLX_FWD_PAYLOAD_TREADY !== 1'b0) begin
      n_err++;
      $display("FAIL rel_ptready: got %b want 0", bus.TLX_FWD_PAYLOAD_TREADY);
    end
    for (int k = 1; k <= 5; k++) begin
      cyc(0, '0, 0, 1);
      n_cmp++;
      if (bus.TLX_FWD_PAYLOAD_TREADY !== 1'b1) begin
        n_err++;
        $display("FAIL init_ptready c%0d: got %b want 1", k,
                 bus.TLX_FWD_PAYLOAD_TREADY);
      end
      n_cmp++;
      if (bus.TLX_FWD_FLOW_TVALID !== (k <= 3)) begin
        n_err++;
        $display("FAIL init_fvalid c%0d: got %b want %b", k,
                 bus.TLX_FWD_FLOW_TVALID, (k <= 3));
      end
      if (k <= 3) begin
        n_cmp++;
        if (bus.TLX_FWD_FLOW_TDATA !== 2'(exp_fd[k-1])) begin
          n_err++;
          $display("FAIL init_fdata c%0d: got %0d want %0d", k,
                   bus.TLX_FWD_FLOW_TDATA, exp_fd[k-1]);
        end
      end
    end
  endtask

  task automatic test_fill_drain();
    int cr = 0;
    for (int i = 1; i <= DEPTH; i++) begin
      cyc(1, DW'(i), 0, 1);
      n_cmp++;
      if (bus.FIFO_LEVEL !== 4'(i)) begin
        n_err++;
        $display("FAIL fill_level %0d: got %0d want %0d", i,
                 bus.FIFO_LEVEL, i);
      end
      n_cmp++;
      if (bus.TLX_FWD_FLOW_TVALID !== 1'b0) begin
        n_err++;
        $display("FAIL fill_noflow %0d: got %b want 0", i,
                 bus.TLX_FWD_FLOW_TVALID);
      end
      n_cmp++;
      if (bus.M_TVALID !== 1'b1 || bus.M_TDATA !== 40'h1) begin
        n_err++;
        $display("FAIL fill_head %0d: got %b/%h want 1/%h", i,
                 bus.M_TVALID, bus.M_TDATA, 40'h1);
      end
    end
    cyc(1, 40'hDEADBEEF00, 0, 1);
    n_cmp++;
    if (bus.OVERFLOW_ERR !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_set: got %b want 1", bus.OVERFLOW_ERR);
    end
    n_cmp++;
    if (bus.FIFO_LEVEL !== 4'd8) begin
      n_err++;
      $display("FAIL ovf_level: got %0d want 8", bus.FIFO_LEVEL);
    end
    for (int i = 0; i < 20; i++) begin
      n_cmp++;
      if (bus.M_TVALID !== (i < DEPTH)) begin
        n_err++;
        $display("FAIL drain_valid %0d: got %b want %b", i,
                 bus.M_TVALID, (i < DEPTH));
      end
      if (i < DEPTH) begin
        n_cmp++;
        if (bus.M_TDATA !== DW'(i + 1)) begin
          n_err++;
          $display("FAIL drain_data %0d: got %h want %h", i,
                   bus.M_TDATA, DW'(i + 1));
        end
      end
      n_cmp++;
      if (bus.TLX_FWD_FLOW_TVALID !== m_fv ||
          (m_fv && bus.TLX_FWD_FLOW_TDATA !== 2'(m_fd))) begin
        n_err++;
        $display("FAIL drain_flow %0d: got %b/%0d want %b/%0d", i,
                 bus.TLX_FWD_FLOW_TVALID, bus.TLX_FWD_FLOW_TDATA, m_fv, m_fd);
      end
      if (bus.TLX_FWD_FLOW_TVALID === 1'b1) cr += int'(bus.TLX_FWD_FLOW_TDATA);
      cyc(0, '0, 1, 1);
    end
    n_cmp++;
    if (cr != DEPTH) begin
      n_err++;
      $display("FAIL drain_credits: got %0d want %0d", cr, DEPTH);
    end
    n_cmp++;
    if (bus.FIFO_LEVEL !== 4'd0) begin
      n_err++;
      $display("FAIL drain_level: got %0d want 0", bus.FIFO_LEVEL);
    end
    n_cmp++;
    if (bus.OVERFLOW_ERR !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_sticky: got %b want 1", bus.OVERFLOW_ERR);
    end
  endtask

  task automatic test_flow_hold();
    int beats[$];
    int seen = 0;
    for (int i = 0; i < 5; i++) cyc(1, DW'(100 + i), 0, 0);
    for (int i = 0; i < 8; i++) begin
      if (bus.TLX_FWD_FLOW_TVALID === 1'b1) begin
        seen++;
        n_cmp++;
        if (bus.TLX_FWD_FLOW_TDATA !== 2'd1) begin
          n_err++;
          $display("FAIL hold_fdata %0d: got %0d want 1", i,
                   bus.TLX_FWD_FLOW_TDATA);
        end
      end
      cyc(0, '0, (i < 5), 0);
    end
    n_cmp++;
    if (seen == 0) begin
      n_err++;
      $display("FAIL hold_seen: got 0 valid cycles want >0");
    end
    for (int i = 0; i < 8; i++) begin
      if (bus.TLX_FWD_FLOW_TVALID === 1'b1)
        beats.push_back(int'(bus.TLX_FWD_FLOW_TDATA));
      cyc(0, '0, 0, 1);
    end
    n_cmp++;
    if (beats.size() != 3) begin
      n_err++;
      $display("FAIL hold_nbeats: got %0d want 3", beats.size());
    end else begin
      n_cmp++;
      if (beats[0] != 1 || beats[1] != 3 || beats[2] != 1) begin
        n_err++;
        $display("FAIL hold_beats: got %0d,%0d,%0d want 1,3,1",
                 beats[0], beats[1], beats[2]);
      end
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 4; i++) cyc(1, DW'(200 + i), 0, 1);
    for (int i = 0; i < 20; i++) begin
      n_cmp++;
      if (bus.FIFO_LEVEL !== 4'd4 || bus.M_TDATA !== mq[0]) begin
        n_err++;
        $display("FAIL wrap %0d: got lvl %0d data %h want 4/%h", i,
                 bus.FIFO_LEVEL, bus.M_TDATA, mq[0]);
      end
      cyc(1, DW'(300 + i), 1, 1);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (bus.M_TVALID !== 1'b1 || bus.M_TDATA !== DW'(316 + i)) begin
        n_err++;
        $display("FAIL wrap_tail %0d: got %b/%h want 1/%h", i,
                 bus.M_TVALID, bus.M_TDATA, DW'(316 + i));
      end
      cyc(0, '0, 1, 1);
    end
  endtask

  task automatic test_random();
    bit pv, mr, fr;
    logic [DW-1:0] pd;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      n_cmp++;
      if (bus.FIFO_LEVEL !== 4'(mq.size()) ||
          bus.M_TVALID !== (mq.size() != 0) ||
          (mq.size() != 0 && bus.M_TDATA !== mq[0]) ||
          bus.TLX_FWD_FLOW_TVALID !== m_fv ||
          (m_fv && bus.TLX_FWD_FLOW_TDATA !== 2'(m_fd)) ||
          bus.OVERFLOW_ERR !== m_ovf ||
          bus.TLX_FWD_PAYLOAD_TREADY !== m_rdy) begin
        n_err++;
        $display("FAIL rand %0d: got lvl%0d v%b d%h f%b/%0d o%b want lvl%0d f%b/%0d o%b",
                 i, bus.FIFO_LEVEL, bus.M_TVALID, bus.M_TDATA,
                 bus.TLX_FWD_FLOW_TVALID, bus.TLX_FWD_FLOW_TDATA,
                 bus.OVERFLOW_ERR, mq.size(), m_fv, m_fd, m_ovf);
      end
      pv = m_rdy && (m_tx > 0) && ($urandom_range(0, 3) != 0);
      pd = {8'($urandom), $urandom};
      mr = ($urandom_range(0, 2) != 0);
      fr = ($urandom_range(0, 3) != 0);
      cyc(pv, pd, mr, fr);
    end
    n_cmp++;
    if (bus.OVERFLOW_ERR !== 1'b0) begin
      n_err++;
      $display("FAIL rand_noovf: got %b want 0", bus.OVERFLOW_ERR);
    end
  endtask

  task automatic test_async_reset();
    int beats[$];
    do_reset();
    for (int i = 0; i < 6; i++) cyc(0, '0, 0, 1);
    for (int i = 0; i < 7; i++) cyc(1, DW'(400 + i), 0, 1);
    for (int i = 0; i < 2; i++) cyc(0, '0, 1, 0);
    n_cmp++;
    if (bus.FIFO_LEVEL !== 4'd5 || m_pend != 2) begin
      n_err++;
      $display("FAIL ar_setup: got lvl %0d pend %0d want 5/2",
               bus.FIFO_LEVEL, m_pend);
    end
    drive(0, '0, 0, 0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.TLX_FWD_PAYLOAD_TREADY !== 1'b0 ||
        bus.TLX_FWD_FLOW_TVALID !== 1'b0 ||
        bus.TLX_FWD_FLOW_TDATA !== 2'd0 ||
        bus.M_TVALID !== 1'b0 ||
        bus.FIFO_LEVEL !== 4'd0 ||
        bus.OVERFLOW_ERR !== 1'b0) begin
      n_err++;
      $display("FAIL ar_outputs: got rdy%b fv%b fd%0d mv%b lvl%0d o%b want all 0",
               bus.TLX_FWD_PAYLOAD_TREADY, bus.TLX_FWD_FLOW_TVALID,
               bus.TLX_FWD_FLOW_TDATA, bus.M_TVALID, bus.FIFO_LEVEL,
               bus.OVERFLOW_ERR);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc(0, '0, 0, 1);
      if (bus.TLX_FWD_FLOW_TVALID === 1'b1)
        beats.push_back(int'(bus.TLX_FWD_FLOW_TDATA));
    end
    n_cmp++;
    if (beats.size() != 3) begin
      n_err++;
      $display("FAIL ar_nbeats: got %0d want 3", beats.size());
    end else begin
      n_cmp++;
      if (beats[0] != 3 || beats[1] != 3 || beats[2] != 2) begin
        n_err++;
        $display("FAIL ar_beats: got %0d,%0d,%0d want 3,3,2",
                 beats[0], beats[1], beats[2]);
      end
    end
    n_cmp++;
    if (bus.FIFO_LEVEL !== 4'd0 || bus.OVERFLOW_ERR !== 1'b0 ||
        bus.M_TVALID !== 1'b0) begin
      n_err++;
      $display("FAIL ar_after: got lvl%0d o%b mv%b want 0/0/0",
               bus.FIFO_LEVEL, bus.OVERFLOW_ERR, bus.M_TVALID);
    end
  endtask

  initial begin
    drive(0, '0, 0, 0);
    test_reset();
    test_fill_drain();
    test_flow_hold();
    test_wrap();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
